// File: rtl/sky130_fd_io__pad_drv_seq.sv
// Core-to-pad output driver sequencer: staged segment enable/disable with hi-Z turnaround.
// Optional DRIVE-state watchdog: define SKY130_FD_IO_PAD_DRV_WDOG_EN.
module sky130_fd_io__pad_drv_seq #(
    parameter int SEGS     = 4,
    parameter int STEP_CYC = 2,
    parameter int TURN_CYC = 3,
    parameter int WDOG_CYC = 1024
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            DATA_IN,
    input  logic            VALID,
    output logic            READY,
    input  logic            RELEASE,
    output logic            PAD_OUT,
    output logic            PAD_OE,
    output logic [SEGS-1:0] DRV_EN,
    output logic            BUSY,
    output logic            WDOG_TRIP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DRIVE,
        S_DOWN,
        S_TURN
    } state_t;

    localparam logic [15:0] STEP_LAST = 16'(STEP_CYC - 1);
    localparam logic [15:0] TURN_LAST = 16'(TURN_CYC - 1);
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);

    state_t          r_state;
    logic            r_ready;
    logic            r_pad;
    logic            r_oe;
    logic [SEGS-1:0] r_drv;
    logic            r_busy;
    logic            r_trip;
    logic [15:0]     r_step;

    logic            w_acc;
    logic [SEGS-1:0] w_up;
    logic [SEGS-1:0] w_dn;
    logic [15:0]     w_step_inc;

    assign w_acc      = VALID & r_ready;
    assign w_up       = (r_drv << 1) | SEGS'(1);
    assign w_dn       = r_drv >> 1;
    assign w_step_inc = (&r_step) ? r_step : r_step + 16'd1;

`ifdef SKY130_FD_IO_PAD_DRV_WDOG_EN
    logic [15:0] r_wdog;
    logic [15:0] w_wdog_inc;
    assign w_wdog_inc = (&r_wdog) ? r_wdog : r_wdog + 16'd1;
`else
    logic w_unused;
    assign w_unused = ^WDOG_LAST;
`endif

    // Sequencer: state, segment thermometer, pad data/enable and handshake
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_pad   <= 1'b0;
            r_oe    <= 1'b0;
            r_drv   <= '0;
            r_busy  <= 1'b0;
            r_trip  <= 1'b0;
            r_step  <= '0;
`ifdef SKY130_FD_IO_PAD_DRV_WDOG_EN
            r_wdog  <= '0;
`endif
        end else begin
            r_trip <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_acc) begin
                        r_pad  <= DATA_IN;
                        r_oe   <= 1'b1;
                        r_drv  <= SEGS'(1);
                        r_busy <= 1'b1;
                        r_step <= '0;
`ifdef SKY130_FD_IO_PAD_DRV_WDOG_EN
                        r_wdog <= '0;
`endif
                        if (SEGS == 1) begin
                            r_state <= S_DRIVE;
                        end else begin
                            r_state <= S_UP;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_UP: begin
                    if (r_step == STEP_LAST) begin
                        r_step <= '0;
                        r_drv  <= w_up;
                        if (&w_up) begin
                            r_state <= S_DRIVE;
                            r_ready <= 1'b1;
`ifdef SKY130_FD_IO_PAD_DRV_WDOG_EN
                            r_wdog  <= '0;
`endif
                        end
                    end else begin
                        r_step <= w_step_inc;
                    end
                end
                S_DRIVE: begin
                    if (w_acc) begin
                        r_pad <= DATA_IN;
`ifdef SKY130_FD_IO_PAD_DRV_WDOG_EN
                        r_wdog <= '0;
`endif
                    end else if (RELEASE) begin
                        r_state <= S_DOWN;
                        r_ready <= 1'b0;
                        r_step  <= STEP_LAST;
`ifdef SKY130_FD_IO_PAD_DRV_WDOG_EN
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state <= S_DOWN;
                        r_ready <= 1'b0;
                        r_step  <= STEP_LAST;
                        r_trip  <= 1'b1;
                    end else begin
                        r_wdog <= w_wdog_inc;
`endif
                    end
                end
                S_DOWN: begin
                    if (r_step == STEP_LAST) begin
                        r_step <= '0;
                        r_drv  <= w_dn;
                        if (w_dn == '0) begin
                            r_oe <= 1'b0;
                            if (TURN_CYC == 0) begin
                                r_state <= S_IDLE;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_TURN;
                            end
                        end
                    end else begin
                        r_step <= w_step_inc;
                    end
                end
                S_TURN: begin
                    if (r_step == TURN_LAST) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_step <= w_step_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign READY     = r_ready;
    assign PAD_OUT   = r_pad;
    assign PAD_OE    = r_oe;
    assign DRV_EN    = r_drv;
    assign BUSY      = r_busy;
    assign WDOG_TRIP = r_trip;

endmodule

// File: tb/tb_sky130_fd_io__pad_drv_seq.sv
// Bench for the pad driver sequencer: directed sequences plus randomized
// traffic checked against a segment-count/phase-timer reference model.
module tb_sky130_fd_io__pad_drv_seq;

    localparam int SEGS     = 4;
    localparam int STEP_CYC = 2;
    localparam int TURN_CYC = 3;
    localparam int WDOG_CYC = 16;

    localparam int P_IDLE = 0;
    localparam int P_UP   = 1;
    localparam int P_DRV  = 2;
    localparam int P_DN   = 3;
    localparam int P_TRN  = 4;

    logic            CLK;
    logic            RESET;
    logic            DATA_IN;
    logic            VALID;
    logic            READY;
    logic            RELEASE;
    logic            PAD_OUT;
    logic            PAD_OE;
    logic [SEGS-1:0] DRV_EN;
    logic            BUSY;
    logic            WDOG_TRIP;

    sky130_fd_io__pad_drv_seq #(
        .SEGS     (SEGS),
        .STEP_CYC (STEP_CYC),
        .TURN_CYC (TURN_CYC),
        .WDOG_CYC (WDOG_CYC)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DATA_IN   (DATA_IN),
        .VALID     (VALID),
        .READY     (READY),
        .RELEASE   (RELEASE),
        .PAD_OUT   (PAD_OUT),
        .PAD_OE    (PAD_OE),
        .DRV_EN    (DRV_EN),
        .BUSY      (BUSY),
        .WDOG_TRIP (WDOG_TRIP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase, clocks spent in phase, segments lit
    int ph;
    int t;
    int lvl;
    int wd;
    bit md;
    bit mrdy;
    bit mtrip;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        ph    = P_IDLE;
        t     = 0;
        lvl   = 0;
        wd    = 0;
        md    = 1'b0;
        mrdy  = 1'b0;
        mtrip = 1'b0;
    endtask

    task automatic m_edge();
        bit acc;
        acc   = VALID && mrdy;
        mtrip = 1'b0;
        case (ph)
            P_IDLE: if (acc) begin
                md  = DATA_IN;
                lvl = 1;
                t   = 0;
                wd  = 0;
                ph  = (SEGS == 1) ? P_DRV : P_UP;
            end
            P_UP: begin
                t++;
                lvl = 1 + t / STEP_CYC;
                if (lvl >= SEGS) begin
                    lvl = SEGS;
                    ph  = P_DRV;
                    wd  = 0;
                end
            end
            P_DRV: begin
                if (acc) begin
                    md = DATA_IN;
                    wd = 0;
                end else if (RELEASE) begin
                    ph = P_DN;
                    t  = 0;
                end else begin
                    wd++;
`ifdef SKY130_FD_IO_PAD_DRV_WDOG_EN
                    if (wd >= WDOG_CYC) begin
                        ph    = P_DN;
                        t     = 0;
                        mtrip = 1'b1;
                    end
`endif
                end
            end
            P_DN: begin
                t++;
                lvl = SEGS - 1 - (t - 1) / STEP_CYC;
                if (lvl <= 0) begin
                    lvl = 0;
                    t   = 0;
                    ph  = (TURN_CYC == 0) ? P_IDLE : P_TRN;
                end
            end
            default: begin
                t++;
                if (t >= TURN_CYC) ph = P_IDLE;
            end
        endcase
        mrdy = (ph == P_IDLE) || (ph == P_DRV);
    endtask

    task automatic cmp_all();
        chk("drv_en", 32'(DRV_EN), 32'((1 << lvl) - 1));
        chk("pad_oe", 32'(PAD_OE), 32'(lvl != 0));
        chk("pad_out", 32'(PAD_OUT), 32'(md));
        chk("ready", 32'(READY), 32'(mrdy));
        chk("busy", 32'(BUSY), 32'(ph != P_IDLE));
        chk("wdog", 32'(WDOG_TRIP), 32'(mtrip));
    endtask

    task automatic cyc();
        @(posedge CLK);
        if (RESET) m_reset();
        else m_edge();
        @(negedge CLK);
        cmp_all();
    endtask

    initial begin
        int up_exp[7];
        int dn_exp[7];
        bit d;
        up_exp = '{1, 1, 3, 3, 7, 7, 15};
        dn_exp = '{7, 7, 3, 3, 1, 1, 0};

        RESET   = 1'b1;
        DATA_IN = 1'b1;
        VALID   = 1'b1;
        RELEASE = 1'b0;
        m_reset();
        #3;
        cmp_all();
        cyc();
        cyc();
        chk("rst_ready", 32'(READY), 32'd0);

        RESET = 1'b0;
        VALID = 1'b0;
        cyc();
        chk("ready_after_rst", 32'(READY), 32'd1);

        VALID   = 1'b1;
        DATA_IN = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("ramp_up", 32'(DRV_EN), 32'(up_exp[i]));
        end
        chk("drive_ready", 32'(READY), 32'd1);
        chk("pad_out_first", 32'(PAD_OUT), 32'd1);

        for (int i = 0; i < 10; i++) begin
            d       = 1'(i & 1);
            DATA_IN = d;
            cyc();
            chk("follow", 32'(PAD_OUT), 32'(d));
            chk("hold_full", 32'(DRV_EN), 32'hF);
        end

        VALID   = 1'b0;
        RELEASE = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("ramp_dn", 32'(DRV_EN), 32'(dn_exp[i]));
        end
        chk("oe_off", 32'(PAD_OE), 32'd0);
        RELEASE = 1'b0;
        cyc();
        cyc();
        chk("turn_busy", 32'(READY), 32'd0);
        cyc();
        chk("turn_done", 32'(READY), 32'd1);

        VALID   = 1'b1;
        DATA_IN = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        DATA_IN = 1'b1;
        RELEASE = 1'b1;
        cyc();
        chk("same_edge_data", 32'(PAD_OUT), 32'd1);
        chk("same_edge_full", 32'(DRV_EN), 32'hF);
        VALID = 1'b0;
        cyc();
        chk("dn_entry", 32'(DRV_EN), 32'hF);
        cyc();
        chk("dn_first", 32'(DRV_EN), 32'h7);
        RELEASE = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("idle_again", 32'(READY), 32'd1);

        VALID = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("mid_ramp", 32'(DRV_EN), 32'h3);
        RESET = 1'b1;
        m_reset();
        #1;
        chk("async_drv", 32'(DRV_EN), 32'd0);
        chk("async_oe", 32'(PAD_OE), 32'd0);
        cyc();
        cyc();
        chk("rst_hold", 32'(DRV_EN), 32'd0);
        RESET = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            VALID   = 1'($urandom % 2);
            DATA_IN = 1'($urandom % 2);
            RELEASE = ($urandom % 4) == 0;
            if (($urandom % 600) == 0) begin
                RESET = 1'b1;
                m_reset();
                #1;
                cmp_all();
                cyc();
                RESET = 1'b0;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
